// File: rtl/xz_check_arbiter.sv
// Round-robin arbiter that sanitizes 4-state request words into a 2-state result,
// flags the X/Z bit positions, and keeps a saturating count of X-bearing results.
module xz_check_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(N_REQ)-1:0] out_id,
  output bit   [WIDTH-1:0]         out_data,
  output logic [WIDTH-1:0]         out_xz_mask,
  output logic                     out_xz,
  input  logic                     cnt_clr,
  output logic [CNT_W-1:0]         xz_count
);
  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [ID_W-1:0]  r_last_grant;
  logic [ID_W-1:0]  r_out_id;
  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] r_out_xz_mask;
  logic             r_out_xz;
  logic [CNT_W-1:0] r_xz_count;

  logic [N_REQ-1:0] w_valid;
  logic [N_REQ-1:0] w_grant;
  logic [ID_W-1:0]  w_grant_idx;
  logic             w_out_ready;
  logic             w_cnt_clr;
  logic             w_eligible;
  logic             w_accept;
  logic [WIDTH-1:0] w_words [N_REQ];
  logic [WIDTH-1:0] w_sel_word;
  logic [WIDTH-1:0] w_is_one;
  logic [WIDTH-1:0] w_is_zero;
  logic [WIDTH-1:0] w_xz_mask;

  // Control bits that are X or Z read as 0 so unknowns never reach state.
  assign w_out_ready = (out_ready === 1'b1);
  assign w_cnt_clr   = (cnt_clr === 1'b1);

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign w_valid[gi] = (req_valid[gi] === 1'b1);
      assign w_words[gi] = req_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Search upward from the slot after the last winner, wrapping around.
  always_comb begin
    logic            found;
    logic [ID_W-1:0] idx;
    w_grant     = '0;
    w_grant_idx = '0;
    found       = 1'b0;
    idx         = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = ID_W'((int'(r_last_grant) + off) % N_REQ);
      if (!found && w_valid[idx]) begin
        found        = 1'b1;
        w_grant_idx  = idx;
        w_grant[idx] = 1'b1;
      end
    end
  end

  assign w_eligible = !rst && ((r_state == S_EMPTY) || w_out_ready);
  assign req_ready  = w_eligible ? w_grant : '0;
  assign w_accept   = |req_ready;

  assign w_sel_word = w_words[w_grant_idx];

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign w_is_one[gi]  = (w_sel_word[gi] === 1'b1);
      assign w_is_zero[gi] = (w_sel_word[gi] === 1'b0);
    end
  endgenerate

  // A bit that is neither a clean 0 nor a clean 1 was X or Z.
  assign w_xz_mask = ~(w_is_one | w_is_zero);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_state_next = S_FULL;
      S_FULL:  if (w_out_ready && !w_accept) w_state_next = S_EMPTY;
      default: w_state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_EMPTY;
      r_last_grant <= ID_W'(N_REQ - 1);
    end else begin
      r_state <= w_state_next;
      if (w_accept) r_last_grant <= w_grant_idx;
    end
  end

  // Result fields change only on acceptance; a plain drain leaves them untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_id      <= '0;
      r_out_data    <= '0;
      r_out_xz_mask <= '0;
      r_out_xz      <= 1'b0;
    end else if (w_accept) begin
      r_out_id      <= w_grant_idx;
      r_out_data    <= w_is_one;
      r_out_xz_mask <= w_xz_mask;
      r_out_xz      <= |w_xz_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_cnt_clr) begin
      r_xz_count <= '0;
    end else if (w_accept && (|w_xz_mask) && (r_xz_count != {CNT_W{1'b1}})) begin
      r_xz_count <= r_xz_count + 1'b1;
    end
  end

  assign out_valid   = (r_state == S_FULL);
  assign out_id      = r_out_id;
  assign out_data    = r_out_data;
  assign out_xz_mask = r_out_xz_mask;
  assign out_xz      = r_out_xz;
  assign xz_count    = r_xz_count;

endmodule
